// File: rtl/uart_pkg.sv
// Shared types and constants for the UART-side register bridge.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_DATA,
    BUS_WR,
    BUS_RD,
    RD_CAP,
    SEND,
    WAIT_DONE
  } bridge_state_t;

  localparam logic [7:0]  UART_ACK  = 8'hA5;
  localparam logic [7:0]  UART_NAK  = 8'hEE;
  localparam int unsigned CMD_W_BIT = 7;

endpackage

// File: rtl/uart_edge_det.sv
// Registered rising-edge detector for a byte-complete level.
module uart_edge_det (
  input  logic sys_clk,
  input  logic reset,
  input  logic level_i,
  output logic rise_o
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = level_i;
    rise_o = level_i & ~prev_q;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= prev_d;
  end

endmodule

// File: rtl/uart_reg_bridge.sv
// Decodes single-byte UART read/write commands, drives a simple register bus
// and returns one response byte per command through the transmitter.
module uart_reg_bridge
  import uart_pkg::*;
#(
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [7:0]        rx_data_i,
  input  logic              tx_done,
  output logic              new_data,
  output logic [7:0]        tx_data_o,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bridge_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        resp_q, resp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        err_q, err_d;
  logic              err_evt;
  logic              rx_rise, tx_rise;
  logic              cmd_illegal;

  uart_edge_det u_rx_edge (.sys_clk(sys_clk), .reset(reset), .level_i(rx_done), .rise_o(rx_rise));
  uart_edge_det u_tx_edge (.sys_clk(sys_clk), .reset(reset), .level_i(tx_done), .rise_o(tx_rise));

  // Reserved command bits are those between the address field and the W bit.
  assign cmd_illegal = ((rx_data_i[6:0] >> ADDR_W) != '0);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    resp_d    = resp_q;
    cnt_d     = cnt_q;
    err_evt   = 1'b0;
    reg_wr_en = 1'b0;
    reg_rd_en = 1'b0;
    new_data  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_rise) begin
          if (cmd_illegal) begin
            resp_d  = UART_NAK;
            err_evt = 1'b1;
            state_d = SEND;
          end else begin
            addr_d = rx_data_i[ADDR_W-1:0];
            if (rx_data_i[CMD_W_BIT]) begin
              cnt_d   = '0;
              state_d = GET_DATA;
            end else begin
              state_d = BUS_RD;
            end
          end
        end
      end
      GET_DATA: begin
        if (rx_rise) begin
          wdata_d = rx_data_i;
          state_d = BUS_WR;
        end else if (cnt_q == CNT_LAST) begin
          err_evt = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BUS_WR: begin
        reg_wr_en = 1'b1;
        resp_d    = UART_ACK;
        state_d   = SEND;
      end
      BUS_RD: begin
        reg_rd_en = 1'b1;
        state_d   = RD_CAP;
      end
      RD_CAP: begin
        resp_d  = reg_rdata;
        state_d = SEND;
      end
      SEND: begin
        new_data = 1'b1;
        state_d  = WAIT_DONE;
      end
      WAIT_DONE: begin
        new_data = 1'b1;
        if (tx_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Bytes arriving while a bus access or response is in flight are dropped.
    if (rx_rise && (state_q != IDLE) && (state_q != GET_DATA)) err_evt = 1'b1;

    err_d = (err_evt && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign tx_data_o = resp_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign err_count = err_q;

endmodule
